usb_tx_data_packer: RTL and testbench
=====================================

Name: usb_tx_data_packer

Overview:
- Transmit-side reader of the endpoint data buffer: drains a programmed number of payload bytes through the buffer's TX read port (get_tx_packet_data / tx_packet_data).
- Frames the payload as a USB DATA packet: PID byte, payload, CRC16 low byte, CRC16 high byte.
- Hands bytes one at a time to the downstream bit-level TX encoder over a valid/ready handshake.
- Sits between data_buffer and the TX serializer / NRZI / bit-stuff stage, under control of the protocol FSM.

Parameters:
- MAX_PAYLOAD, 64, maximum payload bytes per packet; equals buffer depth.
- CNT_W, 7, width of byte_count and buffer_occupancy.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to send a DATA packet; sampled only in IDLE
- pid  in  4  PID nibble (DATA0 = 4'b0011, DATA1 = 4'b1011); latched on accepted start
- byte_count  in  CNT_W  payload length, 0..MAX_PAYLOAD; latched on accepted start
- buffer_occupancy  in  CNT_W  byte count from data_buffer
- tx_packet_data  in  8  head byte of data_buffer TX path; first-word fall-through, valid while occupancy != 0
- get_tx_packet_data  out  1  one-cycle pop of the buffer head
- tx_byte  out  8  byte offered to the TX encoder
- tx_byte_valid  out  1  tx_byte is valid
- tx_byte_ready  in  1  encoder accepts tx_byte this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the CRC high byte is accepted
- err  out  1  one-cycle pulse on rejected start or mid-packet underrun

Behaviour:
- States: IDLE, PID, DATA, CRC_LO, CRC_HI, DONE.
- Reset (rst=1 at a clock edge): state IDLE, crc 16'hFFFF, remaining 0, pid latch 0. All outputs 0: tx_byte 8'h00, tx_byte_valid 0, get_tx_packet_data 0, busy 0, done 0, err 0. Reset mid-packet aborts immediately; no done, no err, no further pops.
- IDLE, start=1 with byte_count > MAX_PAYLOAD or buffer_occupancy < byte_count: err pulses the next cycle; state stays IDLE; nothing popped.
- IDLE, start=1 otherwise: latch pid and byte_count, crc := 16'hFFFF, next state PID. Latency: tx_byte_valid is high the cycle after start is sampled.
- start outside IDLE is ignored.
- PID: tx_byte = {~pid, pid}.
  - On valid&ready: go to DATA if remaining != 0, else CRC_LO.
- DATA: tx_byte = tx_packet_data (combinational pass-through); tx_byte_valid = 1.
  - get_tx_packet_data = tx_byte_valid & tx_byte_ready (pop exactly on the handshake).
  - On the handshake: crc updated with the byte, remaining decremented; remaining reaching 0 goes to CRC_LO.
  - Underrun: buffer_occupancy == 0 while in DATA (e.g. buffer flushed) forces tx_byte_valid 0 and no pop; err pulses and state returns to IDLE on that edge.
- CRC_LO: tx_byte = ~crc[7:0]; advance on handshake.
- CRC_HI: tx_byte = ~crc[15:8]; advance on handshake.
- DONE: done=1 for exactly one cycle, tx_byte_valid 0, then IDLE. busy falls with done's cycle end.
- Handshake rules:
  - tx_byte must stay stable while valid && !ready.
  - ready with valid low has no effect.
  - Back-to-back handshakes every cycle are legal: a 64-byte packet with ready held high takes 67 handshake cycles plus 1 DONE cycle.
- CRC16 (CRC-16/USB): polynomial 0x8005 processed LSB-first (reflected form 0xA001), init 0xFFFF, covers payload bytes only (not PID), result complemented, low byte sent first. Bit-serial or byte-parallel implementation is allowed if single-cycle per byte.
- Simultaneous events:
  - rst overrides start and any handshake.
  - Underrun check takes priority over tx_byte_ready in the same cycle.

Test Plan:
- Zero-length: pid=4'b0011, byte_count=0, ready held 1 -> tx_byte sequence C3, 00, 00; done one cycle after the third handshake; get_tx_packet_data never asserted.
- CRC check: buffer preloaded 31 32 33 34 35 36 37 38 39, pid=4'b1011, byte_count=9 -> bytes 4B, 31..39, C8, B4; exactly 9 pops; occupancy goes 9->0.
- Max payload with backpressure: buffer preloaded 64 bytes 100..163, byte_count=64, tx_byte_ready toggling 1/0 each cycle -> 67 bytes in order, tx_byte stable on stall cycles, pops only on handshake, CRC matches the software model, done once.
- Rejected start: occupancy=20, byte_count=21 -> err pulse, busy stays 0, no pop. Separately, byte_count=65 -> err.
- Underrun: 20-byte packet, buffer flushed after 5 payload handshakes -> tx_byte_valid drops, err pulse, IDLE, no done.
- Reset mid-DATA: rst asserted after 3 payload bytes -> all outputs 0 on the next edge; a new start with byte_count=0 then completes normally (C3 00 00).

Source files
------------

// File: rtl/usb_tx_data_packer.sv
// usb_tx_data_packer: drains a programmed number of payload bytes from the
// endpoint data buffer and frames them as a USB DATA packet
// (PID, payload, CRC16 low, CRC16 high), one byte per valid/ready handshake.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   start, pid, byte_count   packet request from the protocol FSM
//   buffer_occupancy         byte count held in data_buffer
//   tx_packet_data           data_buffer head byte (first-word fall-through)
//   get_tx_packet_data       one-cycle pop of the buffer head
//   tx_byte, tx_byte_valid   byte offered to the TX encoder
//   tx_byte_ready            encoder accepts tx_byte this cycle
//   busy, done, err          status: active, packet complete, rejected/underrun
module usb_tx_data_packer #(
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       pid,
    input  logic [CNT_W-1:0] byte_count,
    input  logic [CNT_W-1:0] buffer_occupancy,
    input  logic [7:0]       tx_packet_data,
    output logic             get_tx_packet_data,
    output logic [7:0]       tx_byte,
    output logic             tx_byte_valid,
    input  logic             tx_byte_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD);
    localparam logic [15:0]      CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      crc_q, crc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [3:0]       pid_q, pid_d;
    logic             err_q, err_d;

    // One payload byte through reflected CRC-16 (poly 0xA001), LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        rem_d         = rem_q;
        pid_d         = pid_q;
        err_d         = 1'b0;
        tx_byte       = 8'h00;
        tx_byte_valid = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((byte_count > MAX_CNT) || (buffer_occupancy < byte_count)) begin
                        err_d = 1'b1;
                    end else begin
                        pid_d   = pid;
                        rem_d   = byte_count;
                        crc_d   = CRC_INIT;
                        state_d = S_PID;
                    end
                end
            end
            S_PID: begin
                tx_byte_valid = 1'b1;
                tx_byte       = {~pid_q, pid_q};
                if (tx_byte_ready) begin
                    state_d = (rem_q != '0) ? S_DATA : S_CRC_LO;
                end
            end
            S_DATA: begin
                // An emptied buffer aborts the packet before any handshake.
                if (buffer_occupancy == '0) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tx_byte_valid = 1'b1;
                    tx_byte       = tx_packet_data;
                    if (tx_byte_ready) begin
                        crc_d = crc16_byte(crc_q, tx_packet_data);
                        rem_d = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = S_CRC_LO;
                        end
                    end
                end
            end
            S_CRC_LO: begin
                tx_byte_valid = 1'b1;
                tx_byte       = ~crc_q[7:0];
                if (tx_byte_ready) state_d = S_CRC_HI;
            end
            S_CRC_HI: begin
                tx_byte_valid = 1'b1;
                tx_byte       = ~crc_q[15:8];
                if (tx_byte_ready) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pop exactly on a payload handshake; reset suppresses it in its own cycle.
    assign get_tx_packet_data = (state_q == S_DATA) && tx_byte_valid && tx_byte_ready && !rst;
    assign busy               = (state_q != S_IDLE);
    assign err                = err_q;

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            crc_q   <= CRC_INIT;
            rem_q   <= '0;
            pid_q   <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            rem_q   <= rem_d;
            pid_q   <= pid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_data_packer.sv
// Directed bench for usb_tx_data_packer; the bench also plays the data_buffer.
module tb_usb_tx_data_packer;

    localparam int unsigned CNT_W = 7;

    logic             clk;
    logic             rst;
    logic             start;
    logic [3:0]       pid;
    logic [CNT_W-1:0] byte_count;
    logic [CNT_W-1:0] buffer_occupancy;
    logic [7:0]       tx_packet_data;
    logic             get_tx_packet_data;
    logic [7:0]       tx_byte;
    logic             tx_byte_valid;
    logic             tx_byte_ready;
    logic             busy;
    logic             done;
    logic             err;

    usb_tx_data_packer #(.MAX_PAYLOAD(64), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .pid                (pid),
        .byte_count         (byte_count),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_byte            (tx_byte),
        .tx_byte_valid      (tx_byte_valid),
        .tx_byte_ready      (tx_byte_ready),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops, pop_viol, stab_viol, done_cnt, err_cnt, cyc, hs_last, done_cyc;
    logic [7:0] buf_q[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] payload[$];
    logic [15:0] crc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        buffer_occupancy = CNT_W'(buf_q.size());
        tx_packet_data   = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
    endtask

    task automatic clear_stats();
        got.delete();
        pops = 0; pop_viol = 0; stab_viol = 0; done_cnt = 0; err_cnt = 0;
        hs_last = -10; done_cyc = -20;
    endtask

    // One clock: log handshake, apply buffer pop after the edge, watch stalls.
    task automatic tick();
        logic g, stall;
        logic [7:0] sb;
        #1;
        g = get_tx_packet_data;
        if (g && !(tx_byte_valid && tx_byte_ready)) pop_viol++;
        if (tx_byte_valid && tx_byte_ready) begin
            got.push_back(tx_byte);
            hs_last = cyc;
        end
        stall = tx_byte_valid && !tx_byte_ready;
        sb    = tx_byte;
        @(posedge clk);
        #1;
        cyc++;
        if (g && buf_q.size() > 0) begin
            void'(buf_q.pop_front());
            pops++;
        end
        refresh();
        #1;
        if (stall && !rst && !(tx_byte_valid && tx_byte === sb)) stab_viol++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
    endtask

    task automatic send(input logic [3:0] p, input logic [CNT_W-1:0] n);
        pid = p; byte_count = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive ready (held or toggling) until done or budget exhausted.
    task automatic run_pkt(input int budget, input bit toggle);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            tx_byte_ready = toggle ? (i % 2 == 0) : 1'b1;
            tick();
        end
        tx_byte_ready = 1'b1;
        tick();
    endtask

    task automatic compare_seq(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
        end
    endtask

    function automatic logic [15:0] crc16_usb(input logic [7:0] d[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[k]) begin
            c = c ^ {8'h00, d[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; pid = 4'h0; byte_count = '0; tx_byte_ready = 1'b0;
        cyc = 0;
        buf_q.delete();
        refresh();
        clear_stats();

        // Reset state
        tick(); tick();
        chk("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
        chk("rst_valid", {31'h0, tx_byte_valid}, 32'h0);
        chk("rst_get", {31'h0, get_tx_packet_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        tick();

        // Zero-length DATA0
        clear_stats();
        tx_byte_ready = 1'b1;
        send(4'b0011, 7'd0);
        chk("zl_latency_valid", {31'h0, tx_byte_valid}, 32'h1);
        chk("zl_latency_byte", {24'h0, tx_byte}, 32'hC3);
        chk("zl_busy", {31'h0, busy}, 32'h1);
        run_pkt(20, 1'b0);
        exp_q = '{8'hC3, 8'h00, 8'h00};
        compare_seq("zl");
        chk("zl_pops", pops, 0);
        chk("zl_done_cnt", done_cnt, 1);
        chk("zl_done_timing", done_cyc, hs_last + 1);
        chk("zl_idle_busy", {31'h0, busy}, 32'h0);

        // CRC check on "123456789" with DATA1
        clear_stats();
        buf_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        refresh();
        chk("crc_occ_start", {25'h0, buffer_occupancy}, 32'd9);
        send(4'b1011, 7'd9);
        run_pkt(40, 1'b0);
        exp_q = '{8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'hC8, 8'hB4};
        compare_seq("crc");
        chk("crc_pops", pops, 9);
        chk("crc_occ_end", {25'h0, buffer_occupancy}, 32'd0);
        chk("crc_done_cnt", done_cnt, 1);
        chk("crc_pop_viol", pop_viol, 0);

        // Max payload with toggling ready
        clear_stats();
        payload.delete();
        for (int i = 0; i < 64; i++) payload.push_back(8'(100 + i));
        buf_q = payload;
        refresh();
        crc = crc16_usb(payload);
        exp_q = '{8'hC3};
        foreach (payload[i]) exp_q.push_back(payload[i]);
        exp_q.push_back(crc[7:0]);
        exp_q.push_back(crc[15:8]);
        send(4'b0011, 7'd64);
        run_pkt(300, 1'b1);
        compare_seq("max");
        chk("max_pops", pops, 64);
        chk("max_pop_viol", pop_viol, 0);
        chk("max_stall_stable", stab_viol, 0);
        chk("max_done_cnt", done_cnt, 1);
        chk("max_busy_end", {31'h0, busy}, 32'h0);

        // Rejected starts
        clear_stats();
        buf_q.delete();
        for (int i = 0; i < 20; i++) buf_q.push_back(8'(i));
        refresh();
        send(4'b0011, 7'd21);
        chk("rej21_err", {31'h0, err}, 32'h1);
        chk("rej21_busy", {31'h0, busy}, 32'h0);
        tick();
        chk("rej21_err_pulse", {31'h0, err}, 32'h0);
        send(4'b0011, 7'd65);
        chk("rej65_err", {31'h0, err}, 32'h1);
        chk("rej65_busy", {31'h0, busy}, 32'h0);
        tick();
        chk("rej_pops", pops, 0);
        chk("rej_err_cnt", err_cnt, 2);

        // Underrun after 5 payload handshakes
        clear_stats();
        send(4'b0011, 7'd20);
        for (int i = 0; i < 40 && got.size() < 6; i++) tick();
        chk("ur_hs_count", got.size(), 6);
        buf_q.delete();
        refresh();
        #1;
        chk("ur_valid_drop", {31'h0, tx_byte_valid}, 32'h0);
        chk("ur_no_pop", {31'h0, get_tx_packet_data}, 32'h0);
        tick();
        chk("ur_err", {31'h0, err}, 32'h1);
        chk("ur_idle", {31'h0, busy}, 32'h0);
        tick();
        chk("ur_err_pulse", {31'h0, err}, 32'h0);
        chk("ur_no_done", done_cnt, 0);
        chk("ur_pops", pops, 5);

        // Reset mid-DATA, then a fresh zero-length packet
        clear_stats();
        buf_q.delete();
        for (int i = 0; i < 10; i++) buf_q.push_back(8'(8'hA0 + i));
        refresh();
        send(4'b0011, 7'd10);
        for (int i = 0; i < 40 && got.size() < 4; i++) tick();
        rst = 1'b1;
        tick();
        chk("mrst_tx_byte", {24'h0, tx_byte}, 32'h0);
        chk("mrst_valid", {31'h0, tx_byte_valid}, 32'h0);
        chk("mrst_get", {31'h0, get_tx_packet_data}, 32'h0);
        chk("mrst_busy", {31'h0, busy}, 32'h0);
        chk("mrst_done_err", {30'h0, done, err}, 32'h0);
        chk("mrst_pops", pops, 3);
        rst = 1'b0;
        buf_q.delete();
        refresh();
        tick();
        clear_stats();
        send(4'b0011, 7'd0);
        run_pkt(20, 1'b0);
        exp_q = '{8'hC3, 8'h00, 8'h00};
        compare_seq("post_rst");
        chk("post_rst_done", done_cnt, 1);
        chk("post_rst_err", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
